// File: rtl/bp_fe_ras_predecode_if.sv
// bp_fe_ras_predecode_if: fetch-in / RAS-strobe-out bundle between the I-cache side and the predecode stage.
interface bp_fe_ras_predecode_if #(
    parameter int vaddr_width_p = 39,
    parameter int ras_els_p     = 8
);
    localparam int depth_w_lp = $clog2(ras_els_p + 1);
    logic                     redirect_i;
    logic                     fetch_v_i;
    logic                     fetch_ready_o;
    logic [vaddr_width_p-1:0] fetch_pc_i;
    logic [31:0]              fetch_instr_i;
    logic                     is_call_o;
    logic                     ovr_ret_o;
    logic [vaddr_width_p-1:0] return_addr_o;
    logic                     ret_pred_v_o;
    logic [depth_w_lp-1:0]    depth_o;
    modport slave (
        input  redirect_i, fetch_v_i, fetch_pc_i, fetch_instr_i,
        output fetch_ready_o, is_call_o, ovr_ret_o, return_addr_o, ret_pred_v_o, depth_o
    );
    modport master (
        output redirect_i, fetch_v_i, fetch_pc_i, fetch_instr_i,
        input  fetch_ready_o, is_call_o, ovr_ret_o, return_addr_o, ret_pred_v_o, depth_o
    );
endinterface

// File: rtl/bp_fe_ras_predecode.sv
// bp_fe_ras_predecode: classifies fetched JAL/JALR by link registers, drives registered RAS push/pop
// strobes with pc+4 and tracks saturating RAS occupancy.
module bp_fe_ras_predecode #(
    parameter int vaddr_width_p = 39,
    parameter int ras_els_p     = 8,
    localparam int dw_lp        = $clog2(ras_els_p + 1)
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    bp_fe_ras_predecode_if.slave fe
);
    typedef enum logic {NORM, POP2PUSH} state_e;
    state_e                   state_q, state_d;
    logic                     is_call_q, is_call_d, ovr_ret_q, ovr_ret_d, ret_pred_v_q, ret_pred_v_d;
    logic [vaddr_width_p-1:0] ret_addr_q, ret_addr_d;
    logic [dw_lp-1:0]         depth_q, depth_d;
    logic [6:0]               opc;
    logic [4:0]               rd, rs1;
    logic                     jal, jalr, lrd, lrs1, push, pop, p2p, accept;
    assign opc    = fe.fetch_instr_i[6:0];
    assign rd     = fe.fetch_instr_i[11:7];
    assign rs1    = fe.fetch_instr_i[19:15];
    assign jal    = opc == 7'b1101111;
    assign jalr   = opc == 7'b1100111 && fe.fetch_instr_i[14:12] == 3'b000;
    assign lrd    = rd == 5'd1 || rd == 5'd5;
    assign lrs1   = rs1 == 5'd1 || rs1 == 5'd5;
    assign push   = (jal || jalr) && lrd;
    assign pop    = jalr && !lrd && lrs1;
    assign p2p    = jalr && lrd && lrs1 && rd != rs1;
    assign fe.fetch_ready_o = state_q == NORM && !reset_i && !fe.redirect_i;
    assign accept = fe.fetch_v_i && fe.fetch_ready_o;
    always_comb begin
        is_call_d  = 1'b0;
        ovr_ret_d  = 1'b0;
        state_d    = NORM;
        ret_addr_d = ret_addr_q;
        // Redirect suppresses both a new decode and the deferred push half of POP2PUSH.
        if (!fe.redirect_i && state_q == POP2PUSH) begin
            is_call_d = 1'b1;
        end else if (!fe.redirect_i && accept) begin
            is_call_d  = push && !p2p;
            ovr_ret_d  = pop || p2p;
            state_d    = p2p ? POP2PUSH : NORM;
            ret_addr_d = fe.fetch_pc_i + vaddr_width_p'(4);
        end
        ret_pred_v_d = ovr_ret_d && depth_q != '0;
        depth_d = is_call_d ? (depth_q == dw_lp'(ras_els_p) ? depth_q : depth_q + dw_lp'(1))
                : ovr_ret_d ? (depth_q == '0 ? depth_q : depth_q - dw_lp'(1))
                : depth_q;
    end
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= NORM;
            is_call_q    <= 1'b0;
            ovr_ret_q    <= 1'b0;
            ret_pred_v_q <= 1'b0;
            ret_addr_q   <= '0;
            depth_q      <= '0;
        end else begin
            state_q      <= state_d;
            is_call_q    <= is_call_d;
            ovr_ret_q    <= ovr_ret_d;
            ret_pred_v_q <= ret_pred_v_d;
            ret_addr_q   <= ret_addr_d;
            depth_q      <= depth_d;
        end
    end
    assign fe.is_call_o     = is_call_q;
    assign fe.ovr_ret_o     = ovr_ret_q;
    assign fe.ret_pred_v_o  = ret_pred_v_q;
    assign fe.return_addr_o = ret_addr_q;
    assign fe.depth_o       = depth_q;
endmodule

// File: tb/tb_bp_fe_ras_predecode.sv
// tb_bp_fe_ras_predecode: directed vector table plus hand sequences for POP2PUSH, saturation, redirect
// and reset corners.
module tb_bp_fe_ras_predecode;
    typedef struct {
        logic [31:0] instr;
        logic [38:0] pc;
        logic        call, ret, pred;
        logic [38:0] addr;
        logic [3:0]  depth;
    } vec_t;
    localparam logic [31:0] JAL_X1 = 32'h0000_00EF, JAL_X5 = 32'h0000_02EF, JAL_X0 = 32'h0000_006F;
    localparam logic [31:0] RET_X1 = 32'h0000_8067, JALR_X0_X6 = 32'h0003_0067, ADDI = 32'h0010_8093;
    localparam logic [31:0] JALR_F3 = 32'h0000_9067, JALR_X1_X1 = 32'h0000_80E7, JALR_X5_X0 = 32'h0000_02E7;
    localparam logic [31:0] RET_X5 = 32'h0002_8067, P2P = 32'h0002_80E7;
    logic clk = 1'b0, rst;
    int   total = 0, bad = 0;
    vec_t tbl[11];
    always #5 clk = ~clk;
    bp_fe_ras_predecode_if #(.vaddr_width_p(39), .ras_els_p(8)) io ();
    bp_fe_ras_predecode dut (.clk_i(clk), .reset_i(rst), .fe(io));
    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask
    task automatic drive(input logic [31:0] instr, input logic [38:0] pc);
        io.fetch_v_i     = 1'b1;
        io.fetch_instr_i = instr;
        io.fetch_pc_i    = pc;
    endtask
    initial begin
        tbl[0]  = '{JAL_X1,     39'h1000, 1, 0, 0, 39'h1004, 4'd1};
        tbl[1]  = '{RET_X1,     39'h1004, 0, 1, 1, 39'h1008, 4'd0};
        tbl[2]  = '{RET_X1,     39'h1008, 0, 1, 0, 39'h100C, 4'd0};
        tbl[3]  = '{JAL_X0,     39'h100C, 0, 0, 0, 39'h1010, 4'd0};
        tbl[4]  = '{JALR_X0_X6, 39'h1010, 0, 0, 0, 39'h1014, 4'd0};
        tbl[5]  = '{ADDI,       39'h1014, 0, 0, 0, 39'h1018, 4'd0};
        tbl[6]  = '{JALR_F3,    39'h1018, 0, 0, 0, 39'h101C, 4'd0};
        tbl[7]  = '{JALR_X1_X1, 39'h3000, 1, 0, 0, 39'h3004, 4'd1};
        tbl[8]  = '{JALR_X5_X0, 39'h3004, 1, 0, 0, 39'h3008, 4'd2};
        tbl[9]  = '{RET_X5,     39'h3008, 0, 1, 1, 39'h300C, 4'd1};
        tbl[10] = '{JAL_X5, 39'h7F_FFFF_FFFC, 1, 0, 0, 39'h0,   4'd2};
        rst = 1'b1;
        io.redirect_i = 1'b0;
        io.fetch_v_i = 1'b0;
        io.fetch_instr_i = '0;
        io.fetch_pc_i = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", 64'(io.fetch_ready_o), 0);
        chk("rst_call", 64'(io.is_call_o), 0);
        chk("rst_ret", 64'(io.ovr_ret_o), 0);
        chk("rst_addr", 64'(io.return_addr_o), 0);
        chk("rst_depth", 64'(io.depth_o), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 64'(io.fetch_ready_o), 1);
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].instr, tbl[i].pc);
            @(negedge clk);
            io.fetch_v_i = 1'b0;
            chk($sformatf("v%0d_call", i), 64'(io.is_call_o), 64'(tbl[i].call));
            chk($sformatf("v%0d_ret", i), 64'(io.ovr_ret_o), 64'(tbl[i].ret));
            chk($sformatf("v%0d_pred", i), 64'(io.ret_pred_v_o), 64'(tbl[i].pred));
            chk($sformatf("v%0d_addr", i), 64'(io.return_addr_o), 64'(tbl[i].addr));
            chk($sformatf("v%0d_depth", i), 64'(io.depth_o), 64'(tbl[i].depth));
            chk($sformatf("v%0d_ready", i), 64'(io.fetch_ready_o), 1);
        end
        // Pop-then-push at depth 2; a fetch offered during POP2PUSH must be ignored.
        drive(P2P, 39'h2000);
        @(negedge clk);
        chk("p2p_ret", 64'(io.ovr_ret_o), 1);
        chk("p2p_call0", 64'(io.is_call_o), 0);
        chk("p2p_pred", 64'(io.ret_pred_v_o), 1);
        chk("p2p_ready0", 64'(io.fetch_ready_o), 0);
        chk("p2p_depth1", 64'(io.depth_o), 1);
        drive(JAL_X1, 39'h5000);
        @(negedge clk);
        io.fetch_v_i = 1'b0;
        chk("p2p_call", 64'(io.is_call_o), 1);
        chk("p2p_ret0", 64'(io.ovr_ret_o), 0);
        chk("p2p_addr", 64'(io.return_addr_o), 64'h2004);
        chk("p2p_depth2", 64'(io.depth_o), 2);
        chk("p2p_ready1", 64'(io.fetch_ready_o), 1);
        @(negedge clk);
        chk("p2p_idle_call", 64'(io.is_call_o), 0);
        // Back-to-back pushes saturate occupancy at 8.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive(JAL_X5, 39'h4000 + 39'(4 * i));
            @(negedge clk);
            chk($sformatf("sat%0d_call", i), 64'(io.is_call_o), 1);
            chk($sformatf("sat%0d_depth", i), 64'(io.depth_o), (i + 1 > 8) ? 64'd8 : 64'(i + 1));
        end
        // Redirect during POP2PUSH drops the push and leaves depth alone.
        drive(P2P, 39'h6000);
        @(negedge clk);
        chk("rd_ret", 64'(io.ovr_ret_o), 1);
        chk("rd_depth7", 64'(io.depth_o), 7);
        io.fetch_v_i = 1'b0;
        io.redirect_i = 1'b1;
        #1 chk("rd_ready0", 64'(io.fetch_ready_o), 0);
        @(negedge clk);
        io.redirect_i = 1'b0;
        chk("rd_no_call", 64'(io.is_call_o), 0);
        chk("rd_no_ret", 64'(io.ovr_ret_o), 0);
        chk("rd_depth", 64'(io.depth_o), 7);
        #1 chk("rd_norm_ready", 64'(io.fetch_ready_o), 1);
        @(negedge clk);
        chk("rd_after_call", 64'(io.is_call_o), 0);
        // Reset during POP2PUSH.
        drive(P2P, 39'h7000);
        @(negedge clk);
        chk("rs_ret", 64'(io.ovr_ret_o), 1);
        io.fetch_v_i = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("rs_call", 64'(io.is_call_o), 0);
        chk("rs_depth", 64'(io.depth_o), 0);
        chk("rs_addr", 64'(io.return_addr_o), 0);
        chk("rs_ready", 64'(io.fetch_ready_o), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rs_ready1", 64'(io.fetch_ready_o), 1);
        chk("rs_call_after", 64'(io.is_call_o), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
